// File: rtl/isla_lane_delay_calib.sv
// Per-lane IDELAY tap calibration: sweeps all taps, finds each lane's widest eye, loads its centre.
// Optional eye statistics (eye_width, pass_map) enabled by defining ISLA_LANE_DELAY_CALIB_EYE_STATS_EN.
module isla_lane_delay_calib #(
    parameter int NUM_LANES       = 8,
    parameter int TAP_WIDTH       = 5,
    parameter int SETTLE_CYCLES   = 16,
    parameter int SAMPLES_PER_TAP = 64,
    parameter int MIN_EYE         = 4
) (
    input  logic                           sys_clk,
    input  logic                           rst,
    input  logic                           calib_start,
    input  logic [TAP_WIDTH-1:0]           manual_tap,
    input  logic [NUM_LANES-1:0]           manual_select,
    input  logic                           manual_load,
    input  logic                           idelay_rdy,
    input  logic                           pattern_valid,
    input  logic [NUM_LANES-1:0]           pattern_ok,
    output logic [TAP_WIDTH-1:0]           delay_value,
    output logic [NUM_LANES-1:0]           delay_load,
    output logic                           busy,
    output logic                           done,
    output logic [NUM_LANES-1:0]           lane_fail,
    output logic [NUM_LANES*TAP_WIDTH-1:0] lane_tap
`ifdef ISLA_LANE_DELAY_CALIB_EYE_STATS_EN
    ,
    output logic [NUM_LANES*(TAP_WIDTH+1)-1:0] eye_width,
    output logic [(1<<TAP_WIDTH)-1:0]          pass_map
`endif
);

    // state    | meaning
    // IDLE     | waiting for calib_start; manual loads accepted
    // WAIT_RDY | waiting for IDELAYCTRL ready
    // LOAD     | drive current tap to all lanes
    // SETTLE   | let the delay line settle, comparator ignored
    // SAMPLE   | accumulate per-lane pass flags over the tap's strobes
    // EVAL     | fold pass flags into run trackers, advance tap
    // APPLY    | load each lane's eye centre, one lane per cycle

    localparam int LANE_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLES_PER_TAP) ? SETTLE_CYCLES : SAMPLES_PER_TAP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int LEN_W   = TAP_WIDTH + 1;
    localparam logic [TAP_WIDTH-1:0] TAP_MAX     = '1;
    localparam logic [CNT_W-1:0]     SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     SAMPLE_LOAD = CNT_W'(SAMPLES_PER_TAP - 1);
    localparam logic [LANE_W-1:0]    LAST_LANE   = LANE_W'(NUM_LANES - 1);

    typedef enum logic [2:0] {IDLE, WAIT_RDY, LOAD, SETTLE, SAMPLE, EVAL, APPLY} state_t;

    state_t                 state;
    logic [TAP_WIDTH-1:0]   tap;
    logic [CNT_W-1:0]       cnt;
    logic [LANE_W-1:0]      apply_idx;
    logic [NUM_LANES-1:0]   pass_flag;
    logic                   manual_prev;
    logic                   manual_edge;
    logic [TAP_WIDTH-1:0]   cur_start      [NUM_LANES];
    logic [TAP_WIDTH-1:0]   best_start     [NUM_LANES];
    logic [LEN_W-1:0]       cur_len        [NUM_LANES];
    logic [LEN_W-1:0]       best_len       [NUM_LANES];
    logic [TAP_WIDTH-1:0]   nxt_cur_start  [NUM_LANES];
    logic [TAP_WIDTH-1:0]   nxt_best_start [NUM_LANES];
    logic [LEN_W-1:0]       nxt_cur_len    [NUM_LANES];
    logic [LEN_W-1:0]       nxt_best_len   [NUM_LANES];
    logic [TAP_WIDTH-1:0]   centre;
    logic                   centre_fail;

    assign manual_edge = manual_load & ~manual_prev;

    // A run is closed by a failing tap or by reaching the last tap; ties keep the earlier run.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            nxt_cur_start[i]  = cur_start[i];
            nxt_cur_len[i]    = cur_len[i];
            nxt_best_start[i] = best_start[i];
            nxt_best_len[i]   = best_len[i];
            if (pass_flag[i]) begin
                if (cur_len[i] == '0)
                    nxt_cur_start[i] = tap;
                nxt_cur_len[i] = cur_len[i] + 1'b1;
            end
            if (!pass_flag[i] || tap == TAP_MAX) begin
                if (nxt_cur_len[i] > best_len[i]) begin
                    nxt_best_start[i] = nxt_cur_start[i];
                    nxt_best_len[i]   = nxt_cur_len[i];
                end
                nxt_cur_len[i] = '0;
            end
        end
    end

    always_comb begin
        centre_fail = best_len[apply_idx] < LEN_W'(MIN_EYE);
        centre      = best_start[apply_idx] + TAP_WIDTH'(best_len[apply_idx] >> 1);
        if (centre_fail)
            centre = '0;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tap         <= '0;
            cnt         <= '0;
            apply_idx   <= '0;
            pass_flag   <= '0;
            manual_prev <= 1'b0;
            delay_value <= '0;
            delay_load  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            lane_fail   <= '0;
            lane_tap    <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                cur_start[i]  <= '0;
                best_start[i] <= '0;
                cur_len[i]    <= '0;
                best_len[i]   <= '0;
            end
`ifdef ISLA_LANE_DELAY_CALIB_EYE_STATS_EN
            eye_width <= '0;
            pass_map  <= '0;
`endif
        end else begin
            manual_prev <= manual_load;
            delay_load  <= '0;
            if (state != IDLE && !idelay_rdy) begin
                tap   <= '0;
                state <= WAIT_RDY;
                for (int i = 0; i < NUM_LANES; i++) begin
                    cur_start[i]  <= '0;
                    best_start[i] <= '0;
                    cur_len[i]    <= '0;
                    best_len[i]   <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (calib_start) begin
                            busy      <= 1'b1;
                            done      <= 1'b0;
                            lane_fail <= '0;
                            lane_tap  <= '0;
                            tap       <= '0;
                            state     <= WAIT_RDY;
                            for (int i = 0; i < NUM_LANES; i++) begin
                                cur_start[i]  <= '0;
                                best_start[i] <= '0;
                                cur_len[i]    <= '0;
                                best_len[i]   <= '0;
                            end
`ifdef ISLA_LANE_DELAY_CALIB_EYE_STATS_EN
                            eye_width <= '0;
`endif
                        end else if (manual_edge) begin
                            delay_value <= manual_tap;
                            delay_load  <= manual_select;
                        end
                    end
                    WAIT_RDY: state <= LOAD;
                    LOAD: begin
                        delay_value <= tap;
                        delay_load  <= '1;
                        cnt         <= SETTLE_LOAD;
                        state       <= SETTLE;
                    end
                    SETTLE: begin
                        if (cnt == '0) begin
                            cnt       <= SAMPLE_LOAD;
                            pass_flag <= '1;
                            state     <= SAMPLE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    SAMPLE: begin
                        if (pattern_valid) begin
                            pass_flag <= pass_flag & pattern_ok;
                            if (cnt == '0)
                                state <= EVAL;
                            else
                                cnt <= cnt - 1'b1;
                        end
                    end
                    EVAL: begin
                        for (int i = 0; i < NUM_LANES; i++) begin
                            cur_start[i]  <= nxt_cur_start[i];
                            cur_len[i]    <= nxt_cur_len[i];
                            best_start[i] <= nxt_best_start[i];
                            best_len[i]   <= nxt_best_len[i];
                        end
`ifdef ISLA_LANE_DELAY_CALIB_EYE_STATS_EN
                        pass_map[tap] <= pass_flag[0];
`endif
                        if (tap == TAP_MAX) begin
                            apply_idx <= '0;
                            state     <= APPLY;
                        end else begin
                            tap   <= tap + 1'b1;
                            state <= LOAD;
                        end
                    end
                    APPLY: begin
                        delay_value <= centre;
                        delay_load  <= NUM_LANES'(1) << apply_idx;
                        lane_tap[apply_idx*TAP_WIDTH +: TAP_WIDTH] <= centre;
                        lane_fail[apply_idx] <= centre_fail;
`ifdef ISLA_LANE_DELAY_CALIB_EYE_STATS_EN
                        eye_width[apply_idx*LEN_W +: LEN_W] <= best_len[apply_idx];
`endif
                        if (apply_idx == LAST_LANE) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            apply_idx <= apply_idx + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_isla_lane_delay_calib.sv
// Scoreboard bench for isla_lane_delay_calib: a behavioural comparator feeds tap-dependent
// pass patterns; expected load pulses are queued per sweep and popped as the DUT emits them.
module tb_isla_lane_delay_calib;
    localparam int NL  = 2;
    localparam int TW  = 5;
    localparam int SET = 4;
    localparam int SPT = 4;
    localparam int ME  = 4;

    logic           sys_clk = 1'b0;
    logic           rst = 1'b1;
    logic           calib_start = 1'b0;
    logic [TW-1:0]  manual_tap = '0;
    logic [NL-1:0]  manual_select = '0;
    logic           manual_load = 1'b0;
    logic           idelay_rdy = 1'b1;
    logic           pattern_valid = 1'b0;
    logic [NL-1:0]  pattern_ok = '0;
    logic [TW-1:0]  delay_value;
    logic [NL-1:0]  delay_load;
    logic           busy;
    logic           done;
    logic [NL-1:0]  lane_fail;
    logic [NL*TW-1:0] lane_tap;
`ifdef ISLA_LANE_DELAY_CALIB_EYE_STATS_EN
    logic [NL*(TW+1)-1:0] eye_width;
    logic [(1<<TW)-1:0]   pass_map;
`endif

    isla_lane_delay_calib #(
        .NUM_LANES(NL), .TAP_WIDTH(TW), .SETTLE_CYCLES(SET),
        .SAMPLES_PER_TAP(SPT), .MIN_EYE(ME)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .calib_start(calib_start),
        .manual_tap(manual_tap), .manual_select(manual_select), .manual_load(manual_load),
        .idelay_rdy(idelay_rdy), .pattern_valid(pattern_valid), .pattern_ok(pattern_ok),
        .delay_value(delay_value), .delay_load(delay_load), .busy(busy), .done(done),
        .lane_fail(lane_fail), .lane_tap(lane_tap)
`ifdef ISLA_LANE_DELAY_CALIB_EYE_STATS_EN
        , .eye_width(eye_width), .pass_map(pass_map)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [NL-1:0] mask;
        logic [TW-1:0] value;
    } pulse_t;

    pulse_t      exp_q[$];
    pulse_t      mon_e;
    int          n_checks = 0;
    int          n_pass = 0;
    int          pulse_cnt = 0;
    int          load_cnt = 0;
    int          last_load_tap = -1;
    int          cur_tap = 0;
    int          since_load = 10000;
    int          nstrobe = 0;
    int          fail_tap = -1;
    logic [31:0] pass_mask [NL];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] r;
        r = '0;
        for (int i = lo; i <= hi; i++)
            r[i] = 1'b1;
        return r;
    endfunction

    // Comparator model: tracks the tap last broadcast to all lanes and strobes
    // every other cycle once the delay line has had time to settle.
    initial begin : comparator
        forever begin
            @(posedge sys_clk);
            #1;
            if (delay_load == '1) begin
                cur_tap       = int'(delay_value);
                last_load_tap = cur_tap;
                since_load    = 0;
                nstrobe       = 0;
                load_cnt++;
            end else if (since_load < 10000) begin
                since_load++;
            end
            pattern_valid = 1'b0;
            if (since_load >= SET + 2 && since_load % 2 == 0) begin
                for (int i = 0; i < NL; i++)
                    pattern_ok[i] = pass_mask[i][cur_tap] &&
                                    !(i == 0 && cur_tap == fail_tap && nstrobe == 1);
                pattern_valid = 1'b1;
                nstrobe++;
            end
        end
    end

    always @(negedge sys_clk) begin
        if (!rst && delay_load != '0 && delay_load != '1) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_pulse", 32'(delay_load), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("pulse_mask", 32'(delay_load), 32'(mon_e.mask));
                check_eq("pulse_value", 32'(delay_value), 32'(mon_e.value));
            end
        end
    end

    task automatic expect_apply(input logic [TW-1:0] t0, input logic [TW-1:0] t1);
        pulse_t p;
        p.mask = 2'b01; p.value = t0; exp_q.push_back(p);
        p.mask = 2'b10; p.value = t1; exp_q.push_back(p);
    endtask

    task automatic pulse_start(input string tag);
        @(posedge sys_clk); #1 calib_start = 1'b1;
        @(posedge sys_clk); #1 calib_start = 1'b0;
        check_eq({tag, "_busy_on_start"}, 32'(busy), 32'd1);
        check_eq({tag, "_done_on_start"}, 32'(done), 32'd0);
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 4000) begin
            @(negedge sys_clk);
            k++;
        end
        if (k >= 4000)
            check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_result(input string tag, input int t0, input int t1, input int fl,
                                input int loads, input int pulses);
        repeat (5) @(negedge sys_clk);
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_lane_tap0"}, 32'(lane_tap[TW-1:0]), 32'(t0));
        check_eq({tag, "_lane_tap1"}, 32'(lane_tap[2*TW-1:TW]), 32'(t1));
        check_eq({tag, "_lane_fail"}, 32'(lane_fail), 32'(fl));
        check_eq({tag, "_load_pulses"}, 32'(loads), 32'(load_cnt));
        check_eq({tag, "_lane_pulses"}, 32'(pulses), 32'(pulse_cnt));
        check_eq({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic sweep(input string tag, input int t0, input int t1, input int fl);
        int l0, p0;
        expect_apply(TW'(t0), TW'(t1));
        l0 = load_cnt;
        p0 = pulse_cnt;
        pulse_start(tag);
        wait_done(tag);
        check_result(tag, t0, t1, fl, l0 + 32, p0 + 2);
    endtask

    initial begin : main
        int l0, p0, k;
        pass_mask[0] = '0;
        pass_mask[1] = '0;

        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_delay_load", 32'(delay_load), 32'd0);
        check_eq("rst_delay_value", 32'(delay_value), 32'd0);
        check_eq("rst_lane_tap", 32'(lane_tap), 32'd0);
        check_eq("rst_lane_fail", 32'(lane_fail), 32'd0);
        @(posedge sys_clk); #1 rst = 1'b0;

        pass_mask[0] = rng(10, 19);
        pass_mask[1] = rng(3, 6) | rng(20, 28);
        sweep("s1", 15, 24, 0);

        pass_mask[1] = rng(0, 2);
        sweep("s2", 15, 0, 2);

        pass_mask[0] = rng(28, 31);
        pass_mask[1] = rng(3, 6) | rng(20, 28);
        sweep("s3", 30, 24, 0);

        pass_mask[0] = rng(10, 19);
        fail_tap = 12;
        sweep("s4_glitch", 16, 24, 0);
        fail_tap = -1;

        pass_mask[0] = rng(2, 5) | rng(20, 23);
        sweep("s4_tie", 4, 24, 0);

        // Manual load while idle: one pulse however long the request is held
        begin
            pulse_t p;
            p.mask = 2'b10; p.value = 5'd7; exp_q.push_back(p);
        end
        p0 = pulse_cnt;
        @(posedge sys_clk); #1;
        manual_tap = 5'd7; manual_select = 2'b10; manual_load = 1'b1;
        repeat (10) @(posedge sys_clk);
        #1 manual_load = 1'b0;
        repeat (4) @(negedge sys_clk);
        check_eq("s5_manual_pulses", 32'(pulse_cnt), 32'(p0 + 1));
        check_eq("s5_manual_queue", 32'(exp_q.size()), 32'd0);
        check_eq("s5_lane_tap0_kept", 32'(lane_tap[TW-1:0]), 32'd4);
        check_eq("s5_lane_tap1_kept", 32'(lane_tap[2*TW-1:TW]), 32'd24);
        check_eq("s5_lane_fail_kept", 32'(lane_fail), 32'd0);

        // Same request during a sweep is discarded
        expect_apply(5'd4, 5'd24);
        l0 = load_cnt;
        p0 = pulse_cnt;
        pulse_start("s5_busy");
        repeat (20) @(posedge sys_clk);
        #1 manual_load = 1'b1;
        repeat (10) @(posedge sys_clk);
        #1 manual_load = 1'b0;
        wait_done("s5_busy");
        check_result("s5_busy", 4, 24, 0, l0 + 32, p0 + 2);

        // idelay_rdy drop at tap 9 restarts the sweep from tap 0
        pass_mask[0] = rng(10, 19);
        expect_apply(5'd15, 5'd24);
        l0 = load_cnt;
        p0 = pulse_cnt;
        last_load_tap = -1;
        pulse_start("s6_drop");
        k = 0;
        while (last_load_tap != 9 && k < 2000) begin
            @(negedge sys_clk);
            k++;
        end
        if (k >= 2000)
            check_eq("s6_reach_tap9_timeout", 32'd0, 32'd1);
        repeat (2) @(posedge sys_clk);
        #1 idelay_rdy = 1'b0;
        repeat (6) @(posedge sys_clk);
        @(negedge sys_clk);
        check_eq("s6_busy_held", 32'(busy), 32'd1);
        check_eq("s6_loads_before_drop", 32'(load_cnt), 32'(l0 + 10));
        k = load_cnt;
        @(posedge sys_clk); #1 idelay_rdy = 1'b1;
        while (load_cnt == k && since_load < 200) @(negedge sys_clk);
        check_eq("s6_restart_tap", 32'(last_load_tap), 32'd0);
        wait_done("s6_drop");
        check_result("s6_drop", 15, 24, 0, l0 + 42, p0 + 2);

        // Asynchronous reset in the middle of SAMPLE
        last_load_tap = -1;
        pulse_start("s6_rst");
        k = 0;
        while (last_load_tap != 3 && k < 2000) begin
            @(negedge sys_clk);
            k++;
        end
        if (k >= 2000)
            check_eq("s6_reach_tap3_timeout", 32'd0, 32'd1);
        repeat (SET + 3) @(posedge sys_clk);
        #2;
        check_eq("s6_busy_before_rst", 32'(busy), 32'd1);
        check_eq("s6_value_before_rst", 32'(delay_value), 32'd3);
        #1 rst = 1'b1;
        #1;
        check_eq("s6_rst_busy", 32'(busy), 32'd0);
        check_eq("s6_rst_done", 32'(done), 32'd0);
        check_eq("s6_rst_delay_value", 32'(delay_value), 32'd0);
        check_eq("s6_rst_delay_load", 32'(delay_load), 32'd0);
        check_eq("s6_rst_lane_tap", 32'(lane_tap), 32'd0);
        check_eq("s6_rst_lane_fail", 32'(lane_fail), 32'd0);
        @(posedge sys_clk); #1 rst = 1'b0;
        repeat (3) @(posedge sys_clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
